reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  Operand register file with a one-entry write-back stage for the 8-bit datapath.
//  Two combinational read ports drive ALU data1/data2.
//  ALU result and carry enter through one write port and sit in a pending stage for one cycle.
//  The pending stage then commits to the array; a read of the pending address is forwarded.
//  Sits between instruction decode and the ALU; it is the source and sink of ALU operands.
// PARAMETERS
//  DATA_W  8  register / ALU operand width
//  ADDR_W  3  register address width; NREGS = 2**ADDR_W (8)
// PORTS
//  CLK          in   1       single clock, all state updates on rising edge
//  RESET        in   1       synchronous, active-high; sampled on rising CLK
//  WRITE        in   1       write request this cycle
//  INADDRESS    in   ADDR_W  destination register of write
//  IN           in   DATA_W  write data (ALU result)
//  IN_CO        in   1       ALU carry accompanying IN
//  FLAG_EN      in   1       1: this write also updates CARRY (add op); 0: carry untouched
//  OUT1ADDRESS  in   ADDR_W  read port 1 address
//  OUT2ADDRESS  in   ADDR_W  read port 2 address
//  OUT1         out  DATA_W  read port 1 data (-> ALU data1)
//  OUT2         out  DATA_W  read port 2 data (-> ALU data2)
//  CARRY        out  1       committed carry flag
//  BUSY         out  1       pending stage holds an uncommitted write
// BEHAVIOUR
//  - Reset (RESET=1 at edge): all NREGS registers <= 0; pend_valid <= 0; CARRY <= 0.
//    RESET overrides a simultaneous WRITE; that write is dropped.
//    A pending write in flight is discarded, not committed.
//  - Outputs after reset: OUT1 = OUT2 = 0, CARRY = 0, BUSY = 0.
//  - Write capture, edge N with WRITE=1: pend_valid<=1; pend_addr<=INADDRESS;
//    pend_data<=IN; pend_co<=IN_CO; pend_flag<=FLAG_EN.
//  - Commit, edge N+1 with pend_valid=1:
//    regs[pend_addr] <= pend_data; if pend_flag, CARRY <= pend_co.
//    pend_valid <= WRITE at that same edge.
//  - Write-to-array latency is 2 edges. Write-to-readable latency is 1 edge (via forward).
//  - Back-to-back writes: every cycle may carry WRITE=1. The previous entry commits while the
//    new entry is captured on the same edge; no stall, no loss.
//  - Same address on consecutive writes: the later write wins in both the array and the forward.
//  - Reads are combinational, independent per port.
//    If pend_valid && OUTxADDRESS==pend_addr: OUTx = pend_data (forward).
//    Otherwise: OUTx = regs[OUTxADDRESS]. Both ports may hit the same address or forward together.
//  - Same-cycle WRITE data is not forwarded; combinational IN never reaches OUTx.
//  - Register 0 is an ordinary writable register (not hardwired).
//  - CARRY changes only at commit of a FLAG_EN write, or at reset.
//    FLAG_EN=0 writes leave it unchanged.
//  - BUSY = pend_valid (registered).
//  - No arithmetic; widths exact, no truncation/extension. Addresses are always in range.
// STRUCTURE
//  - Shared package/header: DATA_W, ADDR_W defaults; ALU opcode constants
//    (FWD=3'b000, ADD=3'b001, AND=3'b010, OR=3'b011).
//    Decode derives FLAG_EN from the opcode.
//  - One sub-module is natural: wb_stage (pending register + forward compare). It exposes
//    pend_valid/pend_addr/pend_data/pend_co/pend_flag. The array and read muxes stay in the top.
// TESTING
//  1. Reset: preload via writes, then assert RESET 1 cycle -> all regs read 0, CARRY=0, BUSY=0.
//  2. Write r3=8'hA5 at edge N, OUT1ADDRESS=3 -> OUT1=A5 after edge N (forward), BUSY=1.
//     After edge N+1 -> still A5 (array), BUSY=0.
//  3. Back-to-back: r1=8'h11, r2=8'h22, r1=8'h33 on consecutive edges -> r1 reads 11,11,33
//     as each lands; end state r1=33, r2=22. No write lost.
//  4. Carry: write IN=8'h04, IN_CO=1, FLAG_EN=1 -> CARRY=1 one edge after capture.
//     Next write IN_CO=0, FLAG_EN=0 -> CARRY stays 1.
//  5. RESET asserted in the same cycle as WRITE r5=8'hFF with a r4 write pending ->
//     r4=0, r5=0, BUSY=0, CARRY=0.
//  6. Dual read: both ports at the pending address 6 (data 8'h5C) -> OUT1=OUT2=5C.
//     Ports at 6 and 7 -> 5C and regs[7].

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared widths and ALU opcode constants for the operand register file and its decode.
package reg_file_wb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  // Only an add produces a meaningful carry, so only ADD updates the flag.
  function automatic logic flag_en_of(input logic [2:0] op);
    return op == OP_ADD;
  endfunction

endpackage

// File: rtl/reg_file_wb_wb_stage.sv
// One-entry write-back stage: holds the last captured write for one cycle and
// reports whether either read address hits it.
module wb_stage
  import reg_file_wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          write,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_co,
  input  logic          flag_en,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          pend_valid,
  output logic [AW-1:0] pend_addr,
  output logic [DW-1:0] pend_data,
  output logic          pend_co,
  output logic          pend_flag,
  output logic          hit1,
  output logic          hit2
);

  logic          pend_valid_reg;
  logic [AW-1:0] pend_addr_reg;
  logic [DW-1:0] pend_data_reg;
  logic          pend_co_reg;
  logic          pend_flag_reg;

  // The entry is replaced every edge; a new write overwrites the one committing now.
  always_ff @(posedge clk) begin
    if (srst) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= '0;
      pend_co_reg    <= 1'b0;
      pend_flag_reg  <= 1'b0;
    end else begin
      pend_valid_reg <= write;
      if (write) begin
        pend_addr_reg <= in_addr;
        pend_data_reg <= in_data;
        pend_co_reg   <= in_co;
        pend_flag_reg <= flag_en;
      end
    end
  end

  assign pend_valid = pend_valid_reg;
  assign pend_addr  = pend_addr_reg;
  assign pend_data  = pend_data_reg;
  assign pend_co    = pend_co_reg;
  assign pend_flag  = pend_flag_reg;

  assign hit1 = pend_valid_reg && (rd1_addr == pend_addr_reg);
  assign hit2 = pend_valid_reg && (rd2_addr == pend_addr_reg);

endmodule

// File: rtl/reg_file_wb.sv
// Operand register file for the 8-bit ALU: two combinational read ports, one
// write port through a pending stage with read forwarding, and a committed carry flag.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WRITE,
  input  logic [AW-1:0] INADDRESS,
  input  logic [DW-1:0] IN,
  input  logic          IN_CO,
  input  logic          FLAG_EN,
  input  logic [AW-1:0] OUT1ADDRESS,
  input  logic [AW-1:0] OUT2ADDRESS,
  output logic [DW-1:0] OUT1,
  output logic [DW-1:0] OUT2,
  output logic          CARRY,
  output logic          BUSY
);

  localparam int NREGS = 1 << AW;

  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic          pend_co;
  logic          pend_flag;
  logic          hit1;
  logic          hit2;

  logic [DW-1:0] regs_reg [NREGS];
  logic          carry_reg;

  wb_stage #(.DW(DW), .AW(AW)) u_wb (
    .clk       (CLK),
    .srst      (RESET),
    .write     (WRITE),
    .in_addr   (INADDRESS),
    .in_data   (IN),
    .in_co     (IN_CO),
    .flag_en   (FLAG_EN),
    .rd1_addr  (OUT1ADDRESS),
    .rd2_addr  (OUT2ADDRESS),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .pend_co   (pend_co),
    .pend_flag (pend_flag),
    .hit1      (hit1),
    .hit2      (hit2)
  );

  // Every register clears on reset, so the array is built from per-entry flops.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    always_ff @(posedge CLK) begin
      if (RESET) begin
        regs_reg[gi] <= '0;
      end else if (pend_valid && (pend_addr == AW'(gi))) begin
        regs_reg[gi] <= pend_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      carry_reg <= 1'b0;
    end else if (pend_valid && pend_flag) begin
      carry_reg <= pend_co;
    end
  end

  assign OUT1  = hit1 ? pend_data : regs_reg[OUT1ADDRESS];
  assign OUT2  = hit2 ? pend_data : regs_reg[OUT2ADDRESS];
  assign CARRY = carry_reg;
  assign BUSY  = pend_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_reg_file_wb;
  import reg_file_wb_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET, WRITE, IN_CO, FLAG_EN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] IN, OUT1, OUT2;
  logic       CARRY, BUSY;

  int checks = 0;
  int errors = 0;

  reg_file_wb dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .IN_CO(IN_CO), .FLAG_EN(FLAG_EN), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2), .CARRY(CARRY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Model: a write is visible to readers right after its capture edge; the
  // carry it carries becomes architectural one edge later; BUSY means "a write
  // was captured at the last edge".
  logic [7:0] m_val [8];
  logic       m_carry, m_busy, m_cq_valid, m_cq_val;
  bit         chk_en = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) m_val[i] = 8'h00;
      m_carry = 1'b0; m_busy = 1'b0; m_cq_valid = 1'b0; m_cq_val = 1'b0;
      chk_en = 1;
    end else begin
      if (m_cq_valid) m_carry = m_cq_val;
      m_cq_valid = 1'b0;
      m_busy = WRITE;
      if (WRITE) begin
        m_val[INADDRESS] = IN;
        if (FLAG_EN) begin
          m_cq_valid = 1'b1;
          m_cq_val   = IN_CO;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("model_out1",  32'(OUT1),  32'(m_val[OUT1ADDRESS]));
      cmp("model_out2",  32'(OUT2),  32'(m_val[OUT2ADDRESS]));
      cmp("model_carry", 32'(CARRY), 32'(m_carry));
      cmp("model_busy",  32'(BUSY),  32'(m_busy));
    end
  end

  task automatic drive(input logic rst, input logic w, input logic [2:0] wa,
                       input logic [7:0] wd, input logic co, input logic fl,
                       input logic [2:0] a1, input logic [2:0] a2);
    RESET = rst; WRITE = w; INADDRESS = wa; IN = wd; IN_CO = co; FLAG_EN = fl;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic note(input string s);
    $display("[%0t] %s", $time, s);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); @(posedge CLK); #1;

    // Reset after preloading every register and setting carry.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 3'(i), 8'(i * 17 + 1), 1'b1, 1'b1, 0, 0);
      note($sformatf("preload r%0d", i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); note("reset"); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      @(negedge CLK);
      cmp("reset_out1", 32'(OUT1), 32'h0);
      cmp("reset_out2", 32'(OUT2), 32'h0);
      tick();
    end
    cmp("reset_carry", 32'(CARRY), 32'h0);
    cmp("reset_busy",  32'(BUSY),  32'h0);

    // Forward, then array read of the same value.
    drive(0, 1, 3, 8'hA5, 0, 0, 3, 0); note("write r3=A5"); tick();
    drive(0, 0, 0, 0, 0, 0, 3, 0); @(negedge CLK);
    cmp("fwd_r3", 32'(OUT1), 32'hA5);
    cmp("fwd_busy", 32'(BUSY), 32'h1);
    tick();
    @(negedge CLK);
    cmp("arr_r3", 32'(OUT1), 32'hA5);
    cmp("arr_busy", 32'(BUSY), 32'h0);
    tick();

    // Back-to-back writes, repeated address.
    drive(0, 1, 1, 8'h11, 0, 0, 1, 2); note("write r1=11"); tick();
    drive(0, 1, 2, 8'h22, 0, 0, 1, 2); note("write r2=22"); @(negedge CLK);
    cmp("b2b_r1_a", 32'(OUT1), 32'h11);
    tick();
    drive(0, 1, 1, 8'h33, 0, 0, 1, 2); note("write r1=33"); @(negedge CLK);
    cmp("b2b_r1_b", 32'(OUT1), 32'h11);
    cmp("b2b_r2_b", 32'(OUT2), 32'h22);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 2); @(negedge CLK);
    cmp("b2b_r1_c", 32'(OUT1), 32'h33);
    tick();
    @(negedge CLK);
    cmp("b2b_r1_end", 32'(OUT1), 32'h33);
    cmp("b2b_r2_end", 32'(OUT2), 32'h22);
    tick();

    // Carry commits one edge after capture; non-flag writes leave it alone.
    drive(0, 1, 0, 8'h04, 1, 1, 0, 0); note("write r0=04 co=1 flag=1"); tick();
    drive(0, 1, 0, 8'h08, 0, 0, 0, 0); note("write r0=08 co=0 flag=0"); @(negedge CLK);
    cmp("carry_before", 32'(CARRY), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); @(negedge CLK);
    cmp("carry_set", 32'(CARRY), 32'h1);
    tick();
    @(negedge CLK);
    cmp("carry_kept", 32'(CARRY), 32'h1);
    cmp("carry_r0", 32'(OUT1), 32'h08);
    tick();

    // Reset wins over a concurrent write and discards the pending one.
    drive(0, 1, 4, 8'h77, 0, 0, 4, 5); note("write r4=77"); tick();
    drive(1, 1, 5, 8'hFF, 1, 1, 4, 5); note("reset with write r5=FF"); tick();
    drive(0, 0, 0, 0, 0, 0, 4, 5); @(negedge CLK);
    cmp("rstw_r4", 32'(OUT1), 32'h0);
    cmp("rstw_r5", 32'(OUT2), 32'h0);
    cmp("rstw_busy", 32'(BUSY), 32'h0);
    cmp("rstw_carry", 32'(CARRY), 32'h0);
    tick();

    // Dual-port forwarding.
    drive(0, 1, 7, 8'h9A, 0, 0, 0, 0); note("write r7=9A"); tick();
    drive(0, 1, 6, 8'h5C, 0, 0, 0, 0); note("write r6=5C"); tick();
    drive(0, 0, 0, 0, 0, 0, 6, 6); @(negedge CLK);
    cmp("dual_p1", 32'(OUT1), 32'h5C);
    cmp("dual_p2", 32'(OUT2), 32'h5C);
    #1 OUT2ADDRESS = 3'd7;
    #1 cmp("dual_67_p1", 32'(OUT1), 32'h5C);
    cmp("dual_67_p2", 32'(OUT2), 32'h9A);
    tick();

    // Randomized traffic; the negedge process compares every cycle.
    note("random phase");
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
